// File: rtl/operand_bypass_unit.sv
// ID-stage operand bypass (EX > MEM > WB > retire buffer > regfile), load-use interlock and ID/EX register.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module operand_bypass_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic [NUM_SRC*DATA_W-1:0] id_regdata_i,
  input  logic                      ex_wen_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_AW-1:0]         ex_waddr_i,
  input  logic [DATA_W-1:0]         ex_result_i,
  input  logic                      mem_wen_i,
  input  logic [REG_AW-1:0]         mem_waddr_i,
  input  logic [DATA_W-1:0]         mem_result_i,
  input  logic                      wb_wen_i,
  input  logic [REG_AW-1:0]         wb_waddr_i,
  input  logic [DATA_W-1:0]         wb_wdata_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic                      op_valid_o,
  output logic [NUM_SRC*DATA_W-1:0] op_data_o,
  output logic [NUM_SRC*3-1:0]      op_fwd_sel_o,
  output logic                      stall_o,
  output logic [31:0]               fwd_cnt_o,
  output logic [31:0]               stall_cnt_o
);

  logic                      op_valid_q;
  logic [NUM_SRC*DATA_W-1:0] op_data_q, op_data_d;
  logic [NUM_SRC*3-1:0]      op_sel_q, op_sel_d;
  logic                      rb_valid_q;
  logic [REG_AW-1:0]         rb_addr_q;
  logic [DATA_W-1:0]         rb_data_q;
  logic                      hazard;

  always_comb begin
    op_data_d = id_regdata_i;
    op_sel_d  = '0;
    hazard    = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      logic [REG_AW-1:0] a;
      logic              live;
      a    = id_src_addr_i[k*REG_AW +: REG_AW];
      live = id_src_used_i[k] && (a != '0);
      if (live && ex_wen_i && ex_waddr_i == a) begin
        op_data_d[k*DATA_W +: DATA_W] = ex_result_i;
        op_sel_d[k*3 +: 3]            = 3'd1;
        // A load's EX result is only an address; the consumer must wait a cycle.
        if (ex_is_load_i) hazard = 1'b1;
      end else if (live && mem_wen_i && mem_waddr_i == a) begin
        op_data_d[k*DATA_W +: DATA_W] = mem_result_i;
        op_sel_d[k*3 +: 3]            = 3'd2;
      end else if (live && wb_wen_i && wb_waddr_i == a) begin
        op_data_d[k*DATA_W +: DATA_W] = wb_wdata_i;
        op_sel_d[k*3 +: 3]            = 3'd3;
      end else if (live && rb_valid_q && rb_addr_q == a) begin
        op_data_d[k*DATA_W +: DATA_W] = rb_data_q;
        op_sel_d[k*3 +: 3]            = 3'd4;
      end
    end
  end

  assign stall_o = id_valid_i && (hazard || hold_i);

  // op_valid_o qualifies op_data_o/op_fwd_sel_o; EX consumes them on any edge where hold_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_valid_q <= 1'b0;
      op_data_q  <= '0;
      op_sel_q   <= '0;
    end else if (flush_i) begin
      op_valid_q <= 1'b0;
    end else if (hold_i) begin
      op_valid_q <= op_valid_q;
    end else if (hazard) begin
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= id_valid_i;
      op_data_q  <= op_data_d;
      op_sel_q   <= op_sel_d;
    end
  end

  // Covers the regfile's write-then-read latency: last non-zero WB write is replayed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rb_valid_q <= 1'b0;
      rb_addr_q  <= '0;
      rb_data_q  <= '0;
    end else if (wb_wen_i && wb_waddr_i != '0) begin
      rb_valid_q <= 1'b1;
      rb_addr_q  <= wb_waddr_i;
      rb_data_q  <= wb_wdata_i;
    end
  end

  assign op_valid_o   = op_valid_q;
  assign op_data_o    = op_data_q;
  assign op_fwd_sel_o = op_sel_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] fwd_cnt_q, stall_cnt_q;
  logic        fwd_evt;

  assign fwd_evt = !flush_i && !hold_i && !hazard && id_valid_i && (op_sel_d != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fwd_evt && fwd_cnt_q != 32'hFFFF_FFFF)  fwd_cnt_q   <= fwd_cnt_q + 32'd1;
      if (hazard && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fwd_cnt_o   = fwd_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign fwd_cnt_o   = 32'd0;
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Randomized + directed bench for operand_bypass_unit with a producer-list reference model and scoreboard.
module tb_operand_bypass_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int EW = 1 + NS*DW + NS*3 + 64;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0] id_src_used;
  logic [NS*DW-1:0] id_regdata;
  logic ex_wen, ex_is_load, mem_wen, wb_wen, hold, flush;
  logic [AW-1:0] ex_waddr, mem_waddr, wb_waddr;
  logic [DW-1:0] ex_result, mem_result, wb_wdata;
  logic op_valid, stall;
  logic [NS*DW-1:0] op_data;
  logic [NS*3-1:0] op_sel;
  logic [31:0] fwd_cnt, stall_cnt;

  always #5 clk = ~clk;

  operand_bypass_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_src_addr_i(id_src_addr),
    .id_src_used_i(id_src_used), .id_regdata_i(id_regdata),
    .ex_wen_i(ex_wen), .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr), .ex_result_i(ex_result),
    .mem_wen_i(mem_wen), .mem_waddr_i(mem_waddr), .mem_result_i(mem_result),
    .wb_wen_i(wb_wen), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .hold_i(hold), .flush_i(flush), .op_valid_o(op_valid), .op_data_o(op_data),
    .op_fwd_sel_o(op_sel), .stall_o(stall), .fwd_cnt_o(fwd_cnt), .stall_cnt_o(stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // Reference state
  logic m_valid;
  logic [NS*DW-1:0] m_data;
  logic [NS*3-1:0] m_sel;
  logic rb_v;
  logic [AW-1:0] rb_a;
  logic [DW-1:0] rb_d;
  logic [31:0] m_fc, m_sc;

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = '0;
    rb_v = 0; rb_a = '0; rb_d = '0; m_fc = 0; m_sc = 0;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_src_addr = '0; id_src_used = '0; id_regdata = '0;
    ex_wen = 0; ex_is_load = 0; ex_waddr = '0; ex_result = '0;
    mem_wen = 0; mem_waddr = '0; mem_result = '0;
    wb_wen = 0; wb_waddr = '0; wb_wdata = '0; hold = 0; flush = 0;
  endtask

  // First producer in age order (youngest first) that writes the operand's register wins.
  task automatic pick(input int k, output logic [DW-1:0] d, output logic [2:0] s, output logic hz);
    logic [AW-1:0] a;
    logic          wen[4];
    logic [AW-1:0] wa[4];
    logic [DW-1:0] wd[4];
    a = id_src_addr[k*AW +: AW];
    d = id_regdata[k*DW +: DW];
    s = 3'd0;
    hz = 1'b0;
    wen[0] = ex_wen;  wa[0] = ex_waddr;  wd[0] = ex_result;
    wen[1] = mem_wen; wa[1] = mem_waddr; wd[1] = mem_result;
    wen[2] = wb_wen;  wa[2] = wb_waddr;  wd[2] = wb_wdata;
    wen[3] = rb_v;    wa[3] = rb_a;      wd[3] = rb_d;
    if (!id_src_used[k] || a == 0) return;
    for (int p = 0; p < 4; p++) begin
      if (wen[p] && wa[p] == a) begin
        d = wd[p];
        s = 3'(p + 1);
        hz = (p == 0) && ex_is_load;
        return;
      end
    end
  endtask

  // Inputs are set just after a negedge; evaluate, predict the next edge, then wait for the next negedge.
  task automatic step();
    logic [NS*DW-1:0] nd;
    logic [NS*3-1:0]  ns_;
    logic             hz;
    logic [DW-1:0]    d;
    logic [2:0]       s;
    logic             h;
    #1;
    hz = 0; nd = '0; ns_ = '0;
    for (int k = 0; k < NS; k++) begin
      pick(k, d, s, h);
      nd[k*DW +: DW] = d;
      ns_[k*3 +: 3] = s;
      hz = hz | h;
    end
    chk("stall", EW'(stall), EW'(id_valid && (hz || hold)));
    if (flush) m_valid = 0;
    else if (hold) ;
    else if (hz) m_valid = 0;
    else begin
      m_valid = id_valid;
      m_data = nd;
      m_sel = ns_;
`ifdef FWD_PERF_CNT_EN
      if (id_valid && ns_ != 0 && m_fc != 32'hFFFF_FFFF) m_fc++;
`endif
    end
`ifdef FWD_PERF_CNT_EN
    if (hz && m_sc != 32'hFFFF_FFFF) m_sc++;
`endif
    if (wb_wen && wb_waddr != 0) begin
      rb_v = 1; rb_a = wb_waddr; rb_d = wb_wdata;
    end
    exp_q.push_back({m_valid, m_data, m_sel, m_fc, m_sc});
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    id_valid = ($urandom_range(0, 9) != 0);
    for (int k = 0; k < NS; k++) begin
      id_src_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      id_regdata[k*DW +: DW] = $urandom;
    end
    id_src_used = NS'($urandom);
    ex_wen = $urandom_range(0, 1); ex_is_load = ($urandom_range(0, 3) == 0);
    ex_waddr = AW'($urandom_range(0, 7)); ex_result = $urandom;
    mem_wen = $urandom_range(0, 1); mem_waddr = AW'($urandom_range(0, 7)); mem_result = $urandom;
    wb_wen = $urandom_range(0, 1); wb_waddr = AW'($urandom_range(0, 7)); wb_wdata = $urandom;
    hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
  endtask

  // Monitor: compares the ID/EX boundary after every edge against the scoreboard.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("idex", {op_valid, op_data, op_sel, fwd_cnt, stall_cnt}, e);
      end
    end
  end

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    #12;
    chk("reset_state", {op_valid, op_data, op_sel, fwd_cnt, stall_cnt}, '0);
    @(negedge clk);
    rst = 0;

    // Youngest producer wins
    clear_inputs();
    id_valid = 1; id_src_used = 2'b01; id_src_addr[0 +: AW] = 5; id_regdata = 64'h0000_0099_0000_0099;
    ex_wen = 1; ex_waddr = 5; ex_result = 32'h11;
    mem_wen = 1; mem_waddr = 5; mem_result = 32'h22;
    wb_wen = 1; wb_waddr = 5; wb_wdata = 32'h33;
    step();
    chk("ex_prio_data", EW'(op_data[31:0]), EW'(32'h11));
    chk("ex_prio_sel", EW'(op_sel[2:0]), EW'(3'd1));

    // Load-use: one bubble then MEM forwarding
    clear_inputs();
    id_valid = 1; id_src_used = 2'b10; id_src_addr[AW +: AW] = 7;
    ex_wen = 1; ex_is_load = 1; ex_waddr = 7; ex_result = 32'h1000;
    #1 chk("load_use_stall", EW'(stall), EW'(1));
    step();
    chk("load_use_bubble", EW'(op_valid), EW'(0));
    ex_wen = 0; ex_is_load = 0;
    mem_wen = 1; mem_waddr = 7; mem_result = 32'hCAFE;
    step();
    chk("load_mem_data", EW'(op_data[63:32]), EW'(32'hCAFE));
    chk("load_mem_sel", EW'(op_sel[5:3]), EW'(3'd2));

    // Unused source matching a load does not stall
    clear_inputs();
    id_valid = 1; id_src_used = 2'b01; id_src_addr[AW +: AW] = 7; id_regdata[63:32] = 32'h1234;
    ex_wen = 1; ex_is_load = 1; ex_waddr = 7;
    #1 chk("unused_no_stall", EW'(stall), EW'(0));
    step();
    chk("unused_sel", EW'(op_sel[5:3]), EW'(3'd0));
    chk("unused_data", EW'(op_data[63:32]), EW'(32'h1234));

    // Retire buffer; r0 never forwarded
    clear_inputs();
    wb_wen = 1; wb_waddr = 3; wb_wdata = 32'hBEEF;
    step();
    clear_inputs();
    wb_wen = 1; wb_waddr = 0; wb_wdata = 32'hDEAD;
    ex_wen = 1; ex_waddr = 0; ex_result = 32'h5;
    id_valid = 1; id_src_used = 2'b11; id_src_addr[0 +: AW] = 3; id_src_addr[AW +: AW] = 0;
    id_regdata = 64'h0000_0077_0000_0000;
    step();
    chk("rb_data", EW'(op_data[31:0]), EW'(32'hBEEF));
    chk("rb_sel", EW'(op_sel[2:0]), EW'(3'd4));
    chk("r0_sel", EW'(op_sel[5:3]), EW'(3'd0));

    // hold for 3 cycles, flush in cycle 2
    clear_inputs();
    id_valid = 1; id_src_used = 2'b01; id_src_addr[0 +: AW] = 2; id_regdata = 64'h5;
    mem_wen = 1; mem_waddr = 2; mem_result = 32'hAB;
    step();
    hold = 1;
    for (int c = 1; c <= 3; c++) begin
      flush = (c == 2);
      id_regdata = $urandom;
      step();
    end
    hold = 0; flush = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset mid-hold
    clear_inputs();
    id_valid = 1; id_src_used = 2'b01; id_src_addr[0 +: AW] = 4; mem_wen = 1; mem_waddr = 4; mem_result = 32'h77;
    step();
    hold = 1;
    step();
    step();
    #2 rst = 1;
    #1;
    chk("async_reset", {op_valid, op_data, op_sel, fwd_cnt, stall_cnt}, '0);
    chk("reset_stall", EW'(stall), EW'(1));
    model_reset();
    @(negedge clk);
    rst = 0;

    // Four load-use hazard cycles
    clear_inputs();
    id_valid = 1; id_src_used = 2'b01; id_src_addr[0 +: AW] = 9;
    ex_wen = 1; ex_is_load = 1; ex_waddr = 9;
    for (int i = 0; i < 4; i++) step();
`ifdef FWD_PERF_CNT_EN
    chk("stall_cnt4", EW'(stall_cnt), EW'(4));
`else
    chk("stall_cnt_off", EW'(stall_cnt), EW'(0));
`endif
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      step();
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/operand_bypass_unit.md
# operand_bypass_unit

Parametrised ID-stage operand bypass and load-use interlock for the 5-stage pipeline. It generalises the 2-operand, 2-source forwarding mux to NUM_SRC operands and four bypass sources (EX, MEM, WB, retired-write buffer), detects load-use hazards itself, and registers the selected operands into the ID/EX boundary. It sits between the register file read ports and the EX stage, and drives the pipeline stall.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width; address 0 is hard-wired zero and never forwarded
- NUM_SRC, 2, number of source operands per instruction (1..4)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- id_valid_i  in  1  ID-stage instruction valid
- id_src_addr_i  in  NUM_SRC*REG_AW  source register addresses; src k at bits [k*REG_AW +: REG_AW]
- id_src_used_i  in  NUM_SRC  per-source "operand actually read"
- id_regdata_i  in  NUM_SRC*DATA_W  register file read data
- ex_wen_i, ex_is_load_i  in  1 each  EX-stage writes a register / EX instruction is a load
- ex_waddr_i  in  REG_AW;  ex_result_i  in  DATA_W  EX-stage destination and ALU result
- mem_wen_i  in  1;  mem_waddr_i  in  REG_AW;  mem_result_i  in  DATA_W  MEM-stage write (load data already merged)
- wb_wen_i  in  1;  wb_waddr_i  in  REG_AW;  wb_wdata_i  in  DATA_W  WB-stage write
- hold_i  in  1  EX stage busy (mul/div); ID/EX must not advance
- flush_i  in  1  kill the instruction entering EX
- op_valid_o  out  1  registered: ID/EX holds a valid instruction
- op_data_o  out  NUM_SRC*DATA_W  registered operands
- op_fwd_sel_o  out  NUM_SRC*3  registered source per operand: 000 regfile, 001 EX, 010 MEM, 011 WB, 100 retire buffer
- stall_o  out  1  combinational: freeze PC and IF/ID this cycle
- fwd_cnt_o, stall_cnt_o  out  32 each  performance counters (see Configuration)

## Operation
- Match k/source S: id_src_used_i[k] && S_wen && S_waddr == id_src_addr_i[k] && addr != 0.
- Priority per operand: EX > MEM > WB > retire buffer > id_regdata_i. Youngest producer wins on multiple matches.
- Load-use: any k matching EX with ex_is_load_i=1 → hazard. Only a used source counts; unused source matching a load must not stall.
- stall_o = id_valid_i && (hazard || hold_i).
- Retire buffer: one entry {valid, addr, data}; loads wb_waddr_i/wb_wdata_i when wb_wen_i && wb_waddr_i != 0; overwritten by every such write; never cleared except by reset. Covers the register file's one-cycle write-to-read latency.
- ID/EX register update per edge, priority order:
  - flush_i: op_valid_o←0; data/sel unchanged.
  - hold_i: all outputs hold.
  - hazard: op_valid_o←0 (bubble).
  - else: op_valid_o←id_valid_i, op_data_o/op_fwd_sel_o←selected values.
- Retire buffer updates regardless of hold_i/flush_i/stall.

## Timing
- Bypass select, hazard, stall_o: combinational, same cycle.
- Operand latency: 1 cycle (ID cycle t → op_data_o valid after edge t+1).
- Load-use: exactly one bubble; in the following cycle the load is in MEM and its data forwards with sel 010.
- hold_i for N cycles: outputs frozen N cycles, stall_o high N cycles; releases on the cycle hold_i falls.
- Reset (any time, including mid-hold or mid-stall): op_valid_o=0, op_data_o=0, op_fwd_sel_o=0, retire buffer invalid, counters 0; stall_o depends only on inputs.

## Configuration
- FWD_PERF_CNT_EN defined: fwd_cnt_o increments on every ID/EX load with op_valid_o←1 and any sel != 000; stall_cnt_o increments every cycle hazard=1. Both saturate at 32'hFFFF_FFFF, clear on reset.
- Undefined: counters not built; fwd_cnt_o and stall_cnt_o tied to 0. Port list unchanged.

## Test plan
- EX writes r5=0x11, MEM writes r5=0x22, WB writes r5=0x33; ID reads r5 on src0 → next cycle op_data src0=0x11, sel 001, stall_o=0.
- ex_is_load_i=1, ex_waddr=r7, ID src1=r7 used → stall_o=1, op_valid_o=0 next cycle; then mem_result_i=0xCAFE → op_data src1=0xCAFE, sel 010.
- Same load but src1 unused (id_src_used_i[1]=0) → no stall; src1 from regfile, sel 000.
- WB writes r3=0xBEEF at t; ID reads r3 at t+1 with regfile returning stale 0 → op_data=0xBEEF, sel 100; r0 writes (wen=1, addr 0) never forwarded.
- hold_i high 3 cycles with flush_i pulsed in cycle 2 → outputs frozen cycle 1, op_valid_o=0 after cycle 2, stall_o high all 3 cycles.
- rst_i asserted asynchronously mid-hold → all outputs and counters 0 immediately; with FWD_PERF_CNT_EN, 4 hazard cycles → stall_cnt_o=4.
